// File: rtl/sipo_loader_pkg.sv
// Shared definitions for the sipo_loader block: FSM state encodings and default geometry.
package sipo_loader_pkg;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_DIV   = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SH_LO = 3'd1,
      SH_HI = 3'd2,
      ST_HI = 3'd3,
      ST_LO = 3'd4
   } state_e;

endpackage

// File: rtl/sipo_loader_if.sv
// Load handshake plus the serial 595 drive pins. Optional oen pin under SIPO_LOADER_OE_EN.
interface sipo_loader_if #(
   parameter int unsigned WIDTH = 16
);
   logic [WIDTH-1:0] load_data;
   logic             load_valid;
   logic             load_ready;
   logic             done;
   logic             ds;
   logic             cp_sh;
   logic             cp_st;
`ifdef SIPO_LOADER_OE_EN
   logic             oen;
`endif

   modport master (
      output load_data, load_valid,
      input  load_ready, done, ds, cp_sh, cp_st
`ifdef SIPO_LOADER_OE_EN
      , input oen
`endif
   );

   modport slave (
      input  load_data, load_valid,
      output load_ready, done, ds, cp_sh, cp_st
`ifdef SIPO_LOADER_OE_EN
      , output oen
`endif
   );
endinterface

// File: rtl/sipo_loader_half_tick.sv
// DIV-cycle down-counter: restart reloads it, expire_o is high on the last cycle of each period.
module sipo_loader_half_tick #(
   parameter int unsigned DIV = 1
) (
   input  logic cp,
   input  logic mrn,
   input  logic restart_i,
   output logic expire_o,
   output logic expire_nxt_c_o
);
   localparam int unsigned CNT_W = $clog2(DIV) + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire_q;

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = CNT_W'(DIV - 1);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Lookahead lets the parent register outputs that coincide with the last cycle.
   assign expire_nxt_c_o = (cnt_d == '0);

   always_ff @(posedge cp or negedge mrn) begin
      if (!mrn) begin
         cnt_q    <= '0;
         expire_q <= 1'b1;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_nxt_c_o;
      end
   end

   assign expire_o = expire_q;
endmodule

// File: rtl/sipo_loader.sv
// Serialises a parallel word MSB-first into a chain of 595 SIPOs, then strobes the storage clock.
// Define SIPO_LOADER_OE_EN to add an oen output held high until the first completed load.
module sipo_loader
   import sipo_loader_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DIV   = DEF_DIV
) (
   input  logic           cp,
   input  logic           mrn,
   sipo_loader_if.slave   bus
);
   localparam int unsigned IDX_W = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             ds_q, ds_d;
   logic             cp_sh_q, cp_sh_d;
   logic             cp_st_q, cp_st_d;
   logic             done_q, done_d;
   logic             ready_q, ready_d;
   logic             restart_c;
   logic             expire;
   logic             expire_nxt_c;

   sipo_loader_half_tick #(.DIV(DIV)) u_half_tick (
      .cp             (cp),
      .mrn            (mrn),
      .restart_i      (restart_c),
      .expire_o       (expire),
      .expire_nxt_c_o (expire_nxt_c)
   );

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (bus.load_valid) begin
               state_d = SH_LO;
               sh_d    = bus.load_data;
               idx_d   = IDX_W'(WIDTH - 1);
            end
         end
         SH_LO: if (expire) state_d = SH_HI;
         SH_HI: begin
            if (expire) begin
               if (idx_q == '0) begin
                  state_d = ST_HI;
               end else begin
                  state_d = SH_LO;
                  idx_d   = idx_q - IDX_W'(1);
                  sh_d    = {sh_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         ST_HI: if (expire) state_d = ST_LO;
         ST_LO: if (expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Pin values are decoded from the next state so they leave flops with no glitches.
      ds_d    = ((state_d == SH_LO) || (state_d == SH_HI)) ? sh_d[WIDTH-1] : 1'b0;
      cp_sh_d = (state_d == SH_HI);
      cp_st_d = (state_d == ST_HI);
      ready_d = (state_d == IDLE);
   end

   assign restart_c = (state_d != state_q);
   assign done_d    = (state_d == ST_LO) && expire_nxt_c;

   always_ff @(posedge cp or negedge mrn) begin
      if (!mrn) begin
         state_q <= IDLE;
         sh_q    <= '0;
         idx_q   <= '0;
         ds_q    <= 1'b0;
         cp_sh_q <= 1'b0;
         cp_st_q <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         idx_q   <= idx_d;
         ds_q    <= ds_d;
         cp_sh_q <= cp_sh_d;
         cp_st_q <= cp_st_d;
         done_q  <= done_d;
         ready_q <= ready_d;
      end
   end

   assign bus.load_ready = ready_q;
   assign bus.done       = done_q;
   assign bus.ds         = ds_q;
   assign bus.cp_sh      = cp_sh_q;
   assign bus.cp_st      = cp_st_q;

`ifdef SIPO_LOADER_OE_EN
   logic oen_q;

   // Keep the 595 outputs tri-stated until a real word has been latched.
   always_ff @(posedge cp or negedge mrn) begin
      if (!mrn) begin
         oen_q <= 1'b1;
      end else if (done_q) begin
         oen_q <= 1'b0;
      end
   end

   assign bus.oen = oen_q;
`endif
endmodule

// File: tb/tb_sipo_loader.sv
// Directed bench: sipo_loader (DIV=1 and DIV=3) driving behavioural two-595 chains.
module tb_sipo_loader;
   import sipo_loader_pkg::*;

   localparam int unsigned W = 16;

   logic cp  = 1'b0;
   logic mrn = 1'b0;
   always #5 cp = ~cp;

   sipo_loader_if #(.WIDTH(W)) bus1 ();
   sipo_loader_if #(.WIDTH(W)) bus3 ();

   sipo_loader #(.WIDTH(W), .DIV(1)) u_dut1 (.cp(cp), .mrn(mrn), .bus(bus1));
   sipo_loader #(.WIDTH(W), .DIV(3)) u_dut3 (.cp(cp), .mrn(mrn), .bus(bus3));

   // Two chained 595s per DUT: shift on cp_sh rise, latch on cp_st rise.
   logic [W-1:0] sr1, st1, sr3, st3;
   int sh_rise1, st_rise1, done_n1, sh_rise3;

   always @(posedge bus1.cp_sh) begin
      sr1 = {sr1[W-2:0], bus1.ds};
      sh_rise1++;
   end
   always @(posedge bus1.cp_st) begin
      st1 = sr1;
      st_rise1++;
   end
   always @(posedge bus3.cp_sh) begin
      sr3 = {sr3[W-2:0], bus3.ds};
      sh_rise3++;
   end
   always @(posedge bus3.cp_st) st3 = sr3;
   always @(negedge cp) if (bus1.done) done_n1++;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Load one word on the DIV=1 DUT; cycle n is the cycle after the n-th edge past accept.
   task automatic run1(input logic [15:0] w, input bit hold, input logic [15:0] alt,
                       output int done_at, output int ready_at);
      int cyc;
      @(negedge cp);
      bus1.load_data  = w;
      bus1.load_valid = 1'b1;
      sh_rise1 = 0;
      st_rise1 = 0;
      done_n1  = 0;
      cyc      = 0;
      done_at  = 0;
      ready_at = 0;
      while (cyc < 400 && ready_at == 0) begin
         @(negedge cp);
         cyc++;
         if (cyc == 1 && !hold) bus1.load_valid = 1'b0;
         if (cyc == 10 && hold) bus1.load_data = alt;
         if (bus1.done && done_at == 0) begin
            done_at = cyc;
            bus1.load_valid = 1'b0;
         end
         if (bus1.load_ready) ready_at = cyc;
      end
   endtask

   int d_at, r_at, cyc, cyc2;
   int rises, hi_run, lo_run, min_hi, max_hi, min_lo, max_lo, min_stab, stab;
   logic prev_sh, prev_ds;

   initial begin
      bus1.load_data = '0; bus1.load_valid = 1'b0;
      bus3.load_data = '0; bus3.load_valid = 1'b0;
      sh_rise1 = 0; st_rise1 = 0; done_n1 = 0; sh_rise3 = 0;

      repeat (3) @(negedge cp);
      check("rst_ready", 64'(bus1.load_ready), 64'd1);
      check("rst_ds",    64'(bus1.ds),         64'd0);
      check("rst_cp_sh", 64'(bus1.cp_sh),      64'd0);
      check("rst_cp_st", 64'(bus1.cp_st),      64'd0);
      check("rst_done",  64'(bus1.done),       64'd0);
`ifdef SIPO_LOADER_OE_EN
      check("rst_oen",   64'(bus1.oen),        64'd1);
`endif
      mrn = 1'b1;

      // 1. Reset after five shifts abandons the word.
      @(negedge cp);
      bus1.load_data = 16'hFFFF; bus1.load_valid = 1'b1;
      sh_rise1 = 0; st_rise1 = 0; done_n1 = 0;
      @(negedge cp);
      bus1.load_valid = 1'b0;
      cyc = 0;
      while (sh_rise1 < 5 && cyc < 50) begin
         @(negedge cp);
         cyc++;
      end
      check("mid_shifts", 64'(sh_rise1), 64'd5);
      #2 mrn = 1'b0;
      #1;
      check("mid_rst_ds",    64'(bus1.ds),         64'd0);
      check("mid_rst_cp_sh", 64'(bus1.cp_sh),      64'd0);
      check("mid_rst_cp_st", 64'(bus1.cp_st),      64'd0);
      check("mid_rst_ready", 64'(bus1.load_ready), 64'd1);
      repeat (3) @(negedge cp);
      mrn = 1'b1;
      repeat (2) @(negedge cp);
      check("mid_no_done", 64'(done_n1),  64'd0);
      check("mid_no_st",   64'(st_rise1), 64'd0);
      run1(16'hA5C3, 1'b0, 16'h0, d_at, r_at);
      check("after_rst_chain", 64'(st1), 64'hA5C3);

      // 2. Single word latency and edge counts.
      run1(16'h0001, 1'b0, 16'h0, d_at, r_at);
      check("w0001_done_at",  64'(d_at),     64'd34);
      check("w0001_ready_at", 64'(r_at),     64'd35);
      check("w0001_sh_rise",  64'(sh_rise1), 64'd16);
      check("w0001_st_rise",  64'(st_rise1), 64'd1);
      check("w0001_done_n",   64'(done_n1),  64'd1);
      check("w0001_chain",    64'(st1),      64'h0001);

      // 3. Back-to-back with load_valid held high.
      @(negedge cp);
      bus1.load_data = 16'hFFFF; bus1.load_valid = 1'b1;
      sh_rise1 = 0; st_rise1 = 0;
      cyc = 0;
      while (!bus1.done && cyc < 200) begin
         @(negedge cp);
         cyc++;
      end
      check("b2b_first_done_at", 64'(cyc), 64'd34);
      check("b2b_chain_ffff",    64'(st1), 64'hFFFF);
      bus1.load_data = 16'h8000;
      @(negedge cp);
      check("b2b_idle_ready", 64'(bus1.load_ready), 64'd1);
      @(negedge cp);
      check("b2b_accepted", 64'(bus1.load_ready), 64'd0);
      bus1.load_valid = 1'b0;
      cyc2 = 1;
      while (!bus1.done && cyc2 < 200) begin
         @(negedge cp);
         cyc2++;
      end
      check("b2b_second_done_at", 64'(cyc2),     64'd34);
      check("b2b_chain_8000",     64'(st1),      64'h8000);
      check("b2b_sh_rise",        64'(sh_rise1), 64'd32);
      check("b2b_st_rise",        64'(st_rise1), 64'd2);
      @(negedge cp);

      // 4. load_data changes while busy are ignored.
      run1(16'h00FF, 1'b1, 16'h1234, d_at, r_at);
      check("busy_chain",    64'(st1),      64'h00FF);
      check("busy_sh_rise",  64'(sh_rise1), 64'd16);
      check("busy_ready_at", 64'(r_at),     64'd35);
      @(negedge cp);
      check("busy_no_reaccept", 64'(bus1.load_ready), 64'd1);

      // 5. DIV=3 phase lengths, setup and latency.
      @(negedge cp);
      bus3.load_data = 16'h5A5A; bus3.load_valid = 1'b1;
      sh_rise3 = 0;
      prev_sh = bus3.cp_sh; prev_ds = bus3.ds;
      rises = 0; hi_run = 0; lo_run = 0; stab = 100;
      min_hi = 99; max_hi = 0; min_lo = 99; max_lo = 0; min_stab = 99;
      d_at = 0; r_at = 0; cyc = 0;
      while (cyc < 400 && r_at == 0) begin
         @(negedge cp);
         cyc++;
         if (cyc == 1) bus3.load_valid = 1'b0;
         if (bus3.cp_sh && !prev_sh) begin
            rises++;
            if (rises > 1) begin
               if (lo_run < min_lo) min_lo = lo_run;
               if (lo_run > max_lo) max_lo = lo_run;
            end
            if (stab < min_stab) min_stab = stab;
            hi_run = 0;
         end
         if (!bus3.cp_sh && prev_sh) begin
            if (hi_run < min_hi) min_hi = hi_run;
            if (hi_run > max_hi) max_hi = hi_run;
            lo_run = 0;
         end
         if (bus3.cp_sh) hi_run++;
         else lo_run++;
         stab = (bus3.ds == prev_ds) ? stab + 1 : 1;
         prev_sh = bus3.cp_sh;
         prev_ds = bus3.ds;
         if (bus3.done && d_at == 0) d_at = cyc;
         if (bus3.load_ready) r_at = cyc;
      end
      check("div3_rises",    64'(rises),    64'd16);
      check("div3_hi_min",   64'(min_hi),   64'd3);
      check("div3_hi_max",   64'(max_hi),   64'd3);
      check("div3_lo_min",   64'(min_lo),   64'd3);
      check("div3_lo_max",   64'(max_lo),   64'd3);
      check("div3_setup",    64'(min_stab >= 3), 64'd1);
      check("div3_done_at",  64'(d_at),     64'd102);
      check("div3_ready_at", 64'(r_at),     64'd103);
      check("div3_chain",    64'(st3),      64'h5A5A);

`ifdef SIPO_LOADER_OE_EN
      // 6. Output enable follows reset and the first completed load.
      @(negedge cp);
      mrn = 1'b0;
      #1;
      check("oe_rst_high", 64'(bus1.oen), 64'd1);
      @(negedge cp);
      mrn = 1'b1;
      @(negedge cp);
      check("oe_idle_high", 64'(bus1.oen), 64'd1);
      run1(16'h1234, 1'b0, 16'h0, d_at, r_at);
      check("oe_chain",    64'(st1),      64'h1234);
      check("oe_after_ld", 64'(bus1.oen), 64'd0);
      #2 mrn = 1'b0;
      #1;
      check("oe_rst_again", 64'(bus1.oen), 64'd1);
      @(negedge cp);
      mrn = 1'b1;
`endif

      repeat (2) @(negedge cp);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
